// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Device frames carry odd parity over the eight data bits plus the parity bit
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus stability filter for one PS/2 line
module ps2_line_filter #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  output logic filt
);

  localparam int CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

  logic             sync_1;
  logic             sync_2;
  logic [CW-1:0]    stable_cnt;

  // Bring the asynchronous line into the clk domain; idle bus level is 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= line;
      sync_2 <= sync_1;
    end
  end

  // Follow the synchronised line only after it differs for FILT consecutive cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_2 == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(FILT - 1)) begin
      filt       <= sync_2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix folding (option: PS2_TIMEOUT_EN)
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       ext,
  output logic       rel,
  output logic       valid,
  output logic       frame_err
);

  logic          clk_f;
  logic          dat_f;
  logic          clk_f_q;
  logic          fall;

  ps2_rx_state_t state_q;
  ps2_rx_state_t state_d;

  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic          par_q;
  logic          ext_pend;
  logic          rel_pend;

  logic          start_ok;
  logic          start_err;
  logic          shift_en;
  logic          par_en;
  logic          frame_ok;
  logic          frame_bad;
  logic          tmo_hit;
  logic          any_err;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (ps2_clk),
    .filt    (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_dat_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (ps2_dat),
    .filt    (dat_f)
  );

  // Remember last filtered clock level so a 1->0 step is seen one cycle late
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_f_q <= 1'b1;
    else          clk_f_q <= clk_f;
  end

  assign fall = clk_f_q & ~clk_f;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Measure ps2_clk silence inside a frame; bus idle time between frames is not timed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          tmo_cnt <= '0;
    else if (fall || state_q == RX_IDLE)   tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state_q != RX_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  // Advance one frame position per detected ps2_clk fall
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = RX_IDLE;
    end else if (fall) begin
      case (state_q)
        RX_IDLE:   if (!dat_f) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP:   state_d = RX_IDLE;
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  // Decode per-fall actions for the datapath
  always_comb begin
    start_ok  = 1'b0;
    start_err = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (fall && !tmo_hit) begin
      case (state_q)
        RX_IDLE: begin
          if (dat_f) start_err = 1'b1;
          else       start_ok  = 1'b1;
        end
        RX_DATA:   shift_en = 1'b1;
        RX_PARITY: par_en   = 1'b1;
        RX_STOP: begin
          if (dat_f && ps2_parity_ok(shift_q, par_q)) frame_ok  = 1'b1;
          else                                        frame_bad = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign any_err = start_err | frame_bad | tmo_hit;

  // Deserialise data bits LSB-first and capture the parity bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shift_q <= {dat_f, shift_q[7:1]};
        if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_q <= dat_f;
      if (any_err) shift_q <= '0;
    end
  end

  // Fold prefixes into pending flags and emit one strobed event per key action
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code      <= '0;
      ext       <= 1'b0;
      rel       <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      rel_pend  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (frame_ok) begin
        if (shift_q == PS2_PFX_EXT) begin
          ext_pend <= 1'b1;
        end else if (shift_q == PS2_PFX_BRK) begin
          rel_pend <= 1'b1;
        end else begin
          code     <= shift_q;
          ext      <= ext_pend;
          rel      <= rel_pend;
          valid    <= 1'b1;
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end
      if (any_err) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        rel_pend  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - scoreboard bench for ps2_scan_rx (timeout case under PS2_TIMEOUT_EN)
module tb_ps2_scan_rx;

  localparam int HALF_BIT = 40;
  localparam int TMO      = 50000;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         rel;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] code;
  logic       ext;
  logic       rel;
  logic       valid;
  logic       frame_err;

  exp_t        sb[$];
  exp_t        e_pop;
  int          checks;
  int          errors;
  int unsigned cyc;
  int unsigned last_fall_cyc;
  int unsigned err_cyc;
  bit          m_ext;
  bit          m_rel;

  ps2_scan_rx #(.FILT(8), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .code      (code),
    .ext       (ext),
    .rel       (rel),
    .valid     (valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare every strobe against the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && (valid || frame_err)) begin
      chk("excl", int'(valid & frame_err), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e_pop = sb.pop_front();
        chk("kind", int'(frame_err), int'(e_pop.is_err));
        if (valid) begin
          chk("code", int'(code), int'(e_pop.code));
          chk("ext",  int'(ext),  int'(e_pop.ext));
          chk("rel",  int'(rel),  int'(e_pop.rel));
        end
        if (frame_err) err_cyc = cyc;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.code = '0; e.ext = 1'b0; e.rel = 1'b0;
    sb.push_back(e);
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  // Drive nbits of a device frame; full good frames update the expected-event model
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] frm;
    logic        par;
    exp_t        e;
    par = ~(^b) ^ bad_par;
    frm = {1'b1, par, b, 1'b0};
    if (nbits == 11) begin
      if (bad_par) begin
        push_err();
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        e.is_err = 1'b0; e.code = b; e.ext = m_ext; e.rel = m_rel;
        sb.push_back(e);
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = frm[i];
      wait_clk(HALF_BIT / 2);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_clk(HALF_BIT);
      ps2_clk = 1'b1;
      if (glitch) begin
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(3);
        ps2_clk = 1'b1;
        wait_clk(HALF_BIT / 2 - 8);
      end else begin
        wait_clk(HALF_BIT / 2);
      end
    end
    ps2_dat = 1'b1;
    wait_clk(3 * HALF_BIT);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      wait_clk(1);
      n++;
    end
    wait_clk(30);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    err_cyc = 0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    reset_n = 1'b0;
    wait_clk(5);
    chk("rst_code",  int'(code), 0);
    chk("rst_ext",   int'(ext), 0);
    chk("rst_rel",   int'(rel), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr",  int'(frame_err), 0);
    reset_n = 1'b1;
    wait_clk(20);

    // 1: plain make code
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    drain("drain_make", 2000);

    // 2: break prefix
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    drain("drain_break", 2000);

    // 3: extended break, then plain make; plus repeated prefix
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 1'b0, 11);
    send_frame(8'hE1, 1'b0, 1'b0, 11);
    drain("drain_ext", 2000);

    // 4: parity error clears pending prefix, then good frame
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    drain("drain_parity", 2000);

    // 5: short glitches on ps2_clk must not add bits
    send_frame(8'h29, 1'b0, 1'b1, 11);
    drain("drain_glitch", 2000);

    // reset mid-frame abandons the frame silently
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h33, 1'b0, 1'b0, 4);
    reset_n = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    wait_clk(4);
    chk("mid_rst_code",  int'(code), 0);
    chk("mid_rst_ext",   int'(ext), 0);
    chk("mid_rst_rel",   int'(rel), 0);
    chk("mid_rst_valid", int'(valid), 0);
    reset_n = 1'b1;
    wait_clk(50);
    send_frame(8'h5A, 1'b0, 1'b0, 11);
    drain("drain_reset", 2000);

`ifdef PS2_TIMEOUT_EN
    // 6: truncated frame times out after TIMEOUT cycles of silence
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h44, 1'b0, 1'b0, 4);
    push_err();
    err_cyc = 0;
    drain("drain_timeout", TMO + 2000);
    chk("tmo_window", int'((err_cyc >= last_fall_cyc + TMO) && (err_cyc <= last_fall_cyc + TMO + 30)), 1);
    send_frame(8'h5A, 1'b0, 1'b0, 11);
    drain("drain_after_tmo", 2000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
